// File: rtl/sift_phase_sequencer.sv
// sift_phase_sequencer: runs the enabled phase engines in index order once per octave
// and muxes the active engine onto the shared image, line-buffer and blur-bank ports
module sift_phase_sequencer #(
  parameter int NUM_PHASES  = 3,
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_W      = 9,
  parameter int NUM_OCTAVES = 1,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_EN  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [NUM_PHASES-1:0]                 phase_en,
  input  logic [NUM_PHASES-1:0]                 phase_done,
  input  logic [NUM_PHASES*ADDR_W-1:0]          phase_img_addr,
  input  logic [NUM_PHASES-1:0]                 phase_buf_we,
  input  logic [NUM_PHASES*NUM_BANKS*ADDR_W-1:0] phase_bank_addr,
  input  logic [NUM_PHASES*NUM_BANKS-1:0]       phase_bank_we,
  output logic [NUM_PHASES-1:0]                 phase_start,
  output logic [ADDR_W-1:0]                     img_addr,
  output logic                                  buf_we,
  output logic [NUM_BANKS*ADDR_W-1:0]           bank_addr,
  output logic [NUM_BANKS-1:0]                  bank_we,
  output logic [2:0]                            cur_phase,
  output logic [2:0]                            cur_octave,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error
);
  typedef enum logic [2:0] {IDLE, RUN, NEXT, FINISH, ERROR} state_t;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);
  localparam logic [2:0] OCT_LAST = 3'(NUM_OCTAVES - 1);
  state_t state, state_n;
  logic [NUM_PHASES-1:0] en_q, en_n, sel;
  logic [2:0] ph_q, ph_n, oct_q, oct_n;
  logic [TIMEOUT_W-1:0] wd_q, wd_n;
  logic [3:0] launch, first, after;
  logic run, live, done_hit, more_oct;
  function automatic logic [3:0] lowest_from(input logic [NUM_PHASES-1:0] m, input int lo);
    lowest_from = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (m[i] && i >= lo) lowest_from = {1'b1, 3'(i)};
  endfunction
  assign launch   = lowest_from(phase_en, 0);
  assign first    = lowest_from(en_q, 0);
  assign after    = lowest_from(en_q, int'(ph_q) + 1);
  assign sel      = NUM_PHASES'(1) << ph_q;
  assign done_hit = |(phase_done & sel);
  assign more_oct = oct_q != OCT_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en_q  <= '0;
      ph_q  <= '0;
      oct_q <= '0;
      wd_q  <= '0;
    end else begin
      state <= state_n;
      en_q  <= en_n;
      ph_q  <= ph_n;
      oct_q <= oct_n;
      wd_q  <= wd_n;
    end
  end
  always_comb begin
    state_n = state;
    en_n    = en_q;
    ph_n    = ph_q;
    oct_n   = oct_q;
    wd_n    = wd_q;
    if (abort) state_n = IDLE;
    else case (state)
      IDLE, ERROR: if (start) begin
        en_n    = phase_en;
        wd_n    = '0;
        state_n = launch[3] ? RUN : FINISH;
        ph_n    = launch[3] ? launch[2:0] : ph_q;
        oct_n   = launch[3] ? 3'd0 : oct_q;
      end
      RUN: begin
        wd_n    = wd_q + 1'b1;
        state_n = done_hit ? NEXT : (TIMEOUT_EN != 0 && wd_q == WD_LAST) ? ERROR : RUN;
      end
      NEXT: begin
        wd_n    = '0;
        state_n = (after[3] || more_oct) ? RUN : FINISH;
        ph_n    = after[3] ? after[2:0] : more_oct ? first[2:0] : ph_q;
        oct_n   = (!after[3] && more_oct) ? oct_q + 3'd1 : oct_q;
      end
      default: state_n = IDLE;
    endcase
  end
  // abort gates the enables in the very cycle it is raised
  assign run         = state == RUN;
  assign live        = run && !abort;
  assign phase_start = live ? sel : '0;
  assign img_addr    = run ? phase_img_addr[int'(ph_q)*ADDR_W +: ADDR_W] : '0;
  assign buf_we      = live && |(phase_buf_we & sel);
  assign bank_addr   = run ? phase_bank_addr[int'(ph_q)*NUM_BANKS*ADDR_W +: NUM_BANKS*ADDR_W] : '0;
  assign bank_we     = live ? phase_bank_we[int'(ph_q)*NUM_BANKS +: NUM_BANKS] : '0;
  assign cur_phase   = ph_q;
  assign cur_octave  = oct_q;
  assign busy        = run || state == NEXT;
  assign done        = state == FINISH;
  assign error       = state == ERROR;
endmodule

// File: tb/tb_sift_phase_sequencer.sv
// tb_sift_phase_sequencer: schedule-queue model checked every cycle, plus hand-computed
// latency and output literals for each directed scenario
module tb_sift_phase_sequencer;
  localparam int NP = 3, NB = 4, AW = 9, NO = 2, TW = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_GAP = 2, M_FIN = 3, M_ERR = 4;
  logic clk = 1'b0, rst, start, abort;
  logic [NP-1:0] phase_en, phase_done, phase_buf_we, phase_start;
  logic [NP*AW-1:0] phase_img_addr;
  logic [NP*NB*AW-1:0] phase_bank_addr;
  logic [NP*NB-1:0] phase_bank_we;
  logic [AW-1:0] img_addr;
  logic buf_we, busy, done, error;
  logic [NB*AW-1:0] bank_addr, e_badr;
  logic [NB-1:0] bank_we;
  logic [2:0] cur_phase, cur_octave;
  logic [AW-1:0] img [NP];
  logic [NB-1:0] bwe [NP];
  logic bufw [NP];
  logic [AW-1:0] badr [NP][NB];
  logic [NP-1:0] stray, ps_hist, e_ps;
  logic [15:0] h_ps [64], h_img [64], h_bwe [64], h_oct [64];
  int dly [NP];
  int vecs = 0, miss = 0;
  int m_mode, m_ph, m_oct, m_cnt, n, d;
  int q_ph [$], q_oct [$];
  bit mvalid = 0, r, g;

  sift_phase_sequencer #(.NUM_PHASES(NP), .NUM_BANKS(NB), .ADDR_W(AW), .NUM_OCTAVES(NO),
    .TIMEOUT_W(TW), .TIMEOUT_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .phase_en(phase_en),
    .phase_done(phase_done), .phase_img_addr(phase_img_addr), .phase_buf_we(phase_buf_we),
    .phase_bank_addr(phase_bank_addr), .phase_bank_we(phase_bank_we),
    .phase_start(phase_start), .img_addr(img_addr), .buf_we(buf_we), .bank_addr(bank_addr),
    .bank_we(bank_we), .cur_phase(cur_phase), .cur_octave(cur_octave), .busy(busy),
    .done(done), .error(error));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_step;
    m_ph  = q_ph.pop_front();
    m_oct = q_oct.pop_front();
    m_cnt = 0;
    m_mode = M_RUN;
  endtask

  // model: a launch expands the mask into the full (octave, phase) schedule
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_mode = M_IDLE; m_ph = 0; m_oct = 0;
      q_ph.delete(); q_oct.delete();
    end else if (abort) m_mode = M_IDLE;
    else if ((m_mode == M_IDLE || m_mode == M_ERR) && start) begin
      q_ph.delete(); q_oct.delete();
      for (int o = 0; o < NO; o++)
        for (int p = 0; p < NP; p++)
          if (phase_en[p]) begin q_ph.push_back(p); q_oct.push_back(o); end
      if (q_ph.size() == 0) m_mode = M_FIN;
      else pop_step();
    end else if (m_mode == M_RUN) begin
      if (phase_done[m_ph]) m_mode = M_GAP;
      else begin
        m_cnt++;
        if (m_cnt == 2**TW - 1) m_mode = M_ERR;
      end
    end else if (m_mode == M_GAP) begin
      if (q_ph.size() == 0) m_mode = M_FIN;
      else pop_step();
    end else if (m_mode == M_FIN) m_mode = M_IDLE;
    mvalid = 1;
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      r = m_mode == M_RUN;
      g = r && !abort;
      e_ps = g ? NP'(1) << m_ph : '0;
      e_badr = '0;
      if (r) for (int b = 0; b < NB; b++) e_badr[b*AW +: AW] = badr[m_ph][b];
      chk("phase_start", phase_start, e_ps);
      chk("img_addr", img_addr, r ? img[m_ph] : '0);
      chk("buf_we", buf_we, g && bufw[m_ph]);
      chk("bank_addr", bank_addr, e_badr);
      chk("bank_we", bank_we, g ? bwe[m_ph] : '0);
      chk("cur_phase", cur_phase, 3'(m_ph));
      chk("cur_octave", cur_octave, 3'(m_oct));
      chk("busy", busy, m_mode == M_RUN || m_mode == M_GAP);
      chk("done", done, m_mode == M_FIN);
      chk("error", error, m_mode == M_ERR);
      ps_hist |= phase_start;
    end
  end

  // engine responder: done after dly[p] consecutive start cycles, or forced via stray
  initial begin
    int run_len [NP];
    phase_done = '0;
    for (int p = 0; p < NP; p++) run_len[p] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int p = 0; p < NP; p++) begin
        run_len[p] = phase_start[p] ? run_len[p] + 1 : 0;
        phase_done[p] = stray[p] | (phase_start[p] && run_len[p] >= dly[p]);
      end
    end
  end

  task automatic run(input logic [NP-1:0] en, input int lim, input int poke, output int cnt);
    phase_en = en;
    start = 1'b1;
    cnt = 0;
    do begin
      tick;
      cnt++;
      start = cnt == poke;
      if (cnt == poke) phase_en = '0;
      if (cnt < 64) begin
        h_ps[cnt] = 16'(phase_start); h_img[cnt] = 16'(img_addr);
        h_bwe[cnt] = 16'(bank_we); h_oct[cnt] = 16'(cur_octave);
      end
    end while (!done && !error && cnt < lim);
    if (!done && !error) chk("run_bound", 0, 1);
  endtask

  initial begin
    img[0] = 9'h1A5; img[1] = 9'h0FF; img[2] = 9'h033;
    bwe[0] = 4'b0101; bwe[1] = 4'b1111; bwe[2] = 4'b0011;
    bufw[0] = 1'b1; bufw[1] = 1'b1; bufw[2] = 1'b0;
    for (int p = 0; p < NP; p++) begin
      phase_img_addr[p*AW +: AW] = img[p];
      phase_buf_we[p] = bufw[p];
      phase_bank_we[p*NB +: NB] = bwe[p];
      dly[p] = 1000;
      for (int b = 0; b < NB; b++) begin
        badr[p][b] = AW'(p*64 + b*8 + 5);
        phase_bank_addr[(p*NB+b)*AW +: AW] = badr[p][b];
      end
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; phase_en = '0; stray = '0; ps_hist = '0;
    repeat (3) tick;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
    chk("rst_phase_start", phase_start, 0); chk("rst_cur_phase", cur_phase, 0);
    rst = 1'b0;
    tick;
    // all phases, two octaves, stray start and mask change mid-run
    for (int p = 0; p < NP; p++) dly[p] = 5;
    run(3'b111, 60, 10, n);
    chk("t1_len", n, 37);
    chk("t1_ps1", h_ps[1], 1); chk("t1_img1", h_img[1], 9'h1A5); chk("t1_bwe1", h_bwe[1], 4'b0101);
    chk("t1_gap_ps", h_ps[6], 0); chk("t1_gap_img", h_img[6], 0); chk("t1_gap_bwe", h_bwe[6], 0);
    chk("t1_ps7", h_ps[7], 2); chk("t1_img7", h_img[7], 9'h0FF); chk("t1_bwe7", h_bwe[7], 4'b1111);
    chk("t1_ps13", h_ps[13], 4); chk("t1_ps19", h_ps[19], 1); chk("t1_oct19", h_oct[19], 1);
    chk("t1_ps31", h_ps[31], 4); chk("t1_oct1", h_oct[1], 0);
    tick;
    chk("t1_idle_busy", busy, 0);
    // phase 1 masked off while its done is held high
    ps_hist = '0;
    for (int p = 0; p < NP; p++) dly[p] = 3;
    stray = 3'b010;
    run(3'b101, 40, 0, n);
    stray = '0;
    chk("t2_len", n, 17); chk("t2_p1_never", ps_hist[1], 0);
    chk("t2_ps5", h_ps[5], 4); chk("t2_oct9", h_oct[9], 1);
    tick;
    // watchdog, then restart from error
    dly[0] = 1000;
    run(3'b001, 40, 0, n);
    chk("t3_timeout_len", n, 16); chk("t3_error", error, 1);
    repeat (3) tick;
    chk("t3_error_sticky", error, 1); chk("t3_busy", busy, 0);
    dly[0] = 2;
    run(3'b001, 40, 0, n);
    chk("t3_restart_len", n, 7); chk("t3_restart_ps1", h_ps[1], 1); chk("t3_cleared", error, 0);
    tick;
    // abort with a simultaneous done
    dly[0] = 1000;
    phase_en = 3'b001; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    abort = 1'b1; stray = 3'b001;
    #1;
    chk("t4_abort_ps", phase_start, 0); chk("t4_abort_bwe", bank_we, 0); chk("t4_abort_buf", buf_we, 0);
    tick;
    abort = 1'b0; stray = '0;
    chk("t4_busy", busy, 0);
    d = 0;
    repeat (10) begin tick; d += int'(done); end
    chk("t4_no_done", d, 0);
    // empty mask
    ps_hist = '0;
    run(3'b000, 10, 0, n);
    chk("t5_len", n, 1);
    tick;
    chk("t5_no_start", ps_hist, 0);
    // reset mid-run, then a clean single-phase run
    for (int p = 0; p < NP; p++) dly[p] = 5;
    phase_en = 3'b111; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    chk("t6_busy", busy, 0); chk("t6_cur_phase", cur_phase, 0);
    rst = 1'b0;
    tick;
    run(3'b010, 40, 0, n);
    chk("t6_len", n, 13);
    repeat (2) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
